// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one registered binary-to-BCD converter
// among N_REQ requesters and keeps the last BCD result for each requester.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no job in flight; pick the next requester round-robin
// WAIT    | converter input driven; count down its pipeline latency
// CAPTURE | converter output valid; store it for the job owner
module bcd_conv_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 12,
    parameter int CONV_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*12-1:0]   req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ*24-1:0]   result,
    output logic [N_REQ-1:0]      result_valid,
    output logic                  busy,
    output logic [11:0]           conv_bindata,
    input  logic [23:0]           conv_decimal
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(CONV_LATENCY + 1);
    localparam logic [PTR_W:0] N_REQ_W = (PTR_W + 1)'(N_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [11:0]        win_data;
    logic [PTR_W-1:0]   next_ptr;

    // Winner: first asserted req scanning upward from rr_ptr with wrap-around.
    always_comb begin
        logic [PTR_W:0] sum;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (sum >= N_REQ_W)
                sum = sum - N_REQ_W;
            if (!win_found && req[sum[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[PTR_W-1:0];
            end
        end
    end

    // Winner's data word and the pointer position just past the winner.
    always_comb begin
        logic [PTR_W:0] nxt;
        win_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_idx == PTR_W'(j))
                win_data = req_data[j*12 +: 12];
        end
        nxt = {1'b0, win_idx} + 1'b1;
        if (nxt == N_REQ_W)
            nxt = '0;
        next_ptr = nxt[PTR_W-1:0];
    end

    // Job sequencing: grant, wait out converter latency, capture result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            cnt          <= '0;
            ack          <= '0;
            result_valid <= '0;
            result       <= '0;
            busy         <= 1'b0;
            conv_bindata <= '0;
        end else begin
            ack          <= '0;
            result_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        conv_bindata <= win_data;
                        ack          <= N_REQ'(1) << win_idx;
                        owner        <= win_idx;
                        rr_ptr       <= next_ptr;
                        cnt          <= CNT_W'(CONV_LATENCY);
                        busy         <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= CAPTURE;
                    else
                        cnt <= cnt - 1'b1;
                end
                CAPTURE: begin
                    for (int j = 0; j < N_REQ; j++) begin
                        if (owner == PTR_W'(j))
                            result[j*24 +: 24] <= conv_decimal;
                    end
                    result_valid <= N_REQ'(1) << owner;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: one instance with a 1-stage converter
// and one with a 3-stage converter, each fed by a behavioural BCD converter.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  req, req3;
    logic [47:0] req_data, req_data3;
    logic [3:0]  ack, ack3;
    logic [95:0] result, result3;
    logic [3:0]  result_valid, result_valid3;
    logic        busy, busy3;
    logic [11:0] conv_bindata, conv_bindata3;
    logic [23:0] conv_decimal, conv_decimal3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_conv_arbiter #(.N_REQ(4), .DATA_W(12), .CONV_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .result(result), .result_valid(result_valid), .busy(busy),
        .conv_bindata(conv_bindata), .conv_decimal(conv_decimal)
    );

    bcd_conv_arbiter #(.N_REQ(4), .DATA_W(12), .CONV_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .req_data(req_data3), .ack(ack3),
        .result(result3), .result_valid(result_valid3), .busy(busy3),
        .conv_bindata(conv_bindata3), .conv_decimal(conv_decimal3)
    );

    function automatic logic [23:0] to_bcd(input logic [11:0] v);
        int n;
        n = int'(v);
        return {8'h00, 4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Behavioural converters: 1 and 3 register stages.
    logic [23:0] pipe1;
    logic [23:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= to_bcd(conv_bindata);
        pipe3[0] <= to_bcd(conv_bindata3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign conv_decimal  = pipe1;
    assign conv_decimal3 = pipe3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; req3 = '0;
        req_data = '0; req_data3 = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ack !== 4'b0)          begin bad++; $display("FAIL reset_ack got=%h want=0", ack); end
        total++; if (result_valid !== 4'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", result_valid); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (conv_bindata !== 12'd0) begin bad++; $display("FAIL reset_bindata got=%0d want=0", conv_bindata); end
        total++; if (result !== 96'd0)      begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    endtask

    task automatic test_single();
        do_reset();
        req_data[11:0] = 12'd1234;
        req = 4'b0001;
        tick();
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b want=0001", ack); end
        total++; if (busy !== 1'b1)   begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        total++; if (conv_bindata !== 12'd1234) begin bad++; $display("FAIL single_bindata got=%0d want=1234", conv_bindata); end
        req = 4'b0000;
        tick();
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL single_ack_pulse got=%b want=0000", ack); end
        tick();
        total++; if (result_valid !== 4'b0000) begin bad++; $display("FAIL single_early_valid got=%b want=0000", result_valid); end
        tick();
        total++; if (result_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b want=0001", result_valid); end
        total++; if (result[23:0] !== 24'h001234) begin bad++; $display("FAIL single_result got=%h want=001234", result[23:0]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
        tick();
        total++; if (result_valid !== 4'b0000) begin bad++; $display("FAIL single_valid_pulse got=%b want=0000", result_valid); end
    endtask

    task automatic test_simultaneous();
        logic [23:0] exp_res [4];
        int c;
        exp_res[0] = 24'h000000; exp_res[1] = 24'h004095;
        exp_res[2] = 24'h000100; exp_res[3] = 24'h000009;
        do_reset();
        req_data = {12'd9, 12'd100, 12'd4095, 12'd0};
        req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            c = 0;
            do begin tick(); c++; end while (ack === 4'b0 && c < 20);
            total++; if (ack !== (4'b0001 << j)) begin bad++; $display("FAIL simul_grant%0d got=%b want=%b", j, ack, 4'b0001 << j); end
            req = req & ~ack;
            c = 0;
            do begin tick(); c++; end while (result_valid === 4'b0 && c < 20);
            total++; if (result_valid !== (4'b0001 << j)) begin bad++; $display("FAIL simul_valid%0d got=%b want=%b", j, result_valid, 4'b0001 << j); end
            total++; if (result[j*24 +: 24] !== exp_res[j]) begin bad++; $display("FAIL simul_result%0d got=%h want=%h", j, result[j*24 +: 24], exp_res[j]); end
        end
    endtask

    task automatic test_fairness();
        int c;
        int exp_ch;
        do_reset();
        req_data[11:0]  = 12'd11;
        req_data[35:24] = 12'd22;
        req = 4'b0101;
        for (int g = 0; g < 6; g++) begin
            exp_ch = (g % 2 == 0) ? 0 : 2;
            c = 0;
            do begin tick(); c++; end while (ack === 4'b0 && c < 20);
            total++; if (ack !== (4'b0001 << exp_ch)) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", g, ack, 4'b0001 << exp_ch); end
            if (ack[0]) begin
                req[0] = 1'b0;
                tick();
                req[0] = 1'b1;
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_abort();
        bit saw_valid;
        do_reset();
        req_data[23:12] = 12'd77;
        req = 4'b0010;
        tick();
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL abort_ack got=%b want=0010", ack); end
        req = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (conv_bindata !== 12'd0) begin bad++; $display("FAIL abort_bindata got=%0d want=0", conv_bindata); end
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (result_valid !== 4'b0) saw_valid = 1'b1;
        end
        total++; if (saw_valid) begin bad++; $display("FAIL abort_no_valid got=1 want=0"); end
        total++; if (result[47:24] !== 24'h0) begin bad++; $display("FAIL abort_result1 got=%h want=000000", result[47:24]); end
        req_data[11:0] = 12'd5;
        req = 4'b0011;
        tick();
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL abort_next_grant got=%b want=0001", ack); end
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_latency3();
        bit unstable;
        do_reset();
        req_data3[47:36] = 12'd999;
        req3 = 4'b1000;
        tick();
        total++; if (ack3 !== 4'b1000) begin bad++; $display("FAIL lat3_ack got=%b want=1000", ack3); end
        total++; if (conv_bindata3 !== 12'd999) begin bad++; $display("FAIL lat3_bindata got=%0d want=999", conv_bindata3); end
        req3 = 4'b0000;
        req_data3[47:36] = 12'd5;
        unstable = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (conv_bindata3 !== 12'd999) unstable = 1'b1;
            total++; if (result_valid3 !== 4'b0) begin bad++; $display("FAIL lat3_early_valid c%0d got=%b want=0000", i, result_valid3); end
        end
        total++; if (unstable) begin bad++; $display("FAIL lat3_bindata_stable got=changed want=999"); end
        tick();
        total++; if (result_valid3 !== 4'b1000) begin bad++; $display("FAIL lat3_valid got=%b want=1000", result_valid3); end
        total++; if (result3[95:72] !== 24'h000999) begin bad++; $display("FAIL lat3_result got=%h want=000999", result3[95:72]); end
    endtask

    task automatic test_sampling_withdraw();
        bit saw_ack2;
        do_reset();
        req_data[11:0]  = 12'd321;
        req_data[35:24] = 12'd42;
        req = 4'b0001;
        tick();
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL samp_ack got=%b want=0001", ack); end
        req_data[11:0] = 12'd555;
        req = 4'b0100;
        saw_ack2 = 1'b0;
        tick();
        if (ack[2]) saw_ack2 = 1'b1;
        req = 4'b0000;
        tick();
        if (ack[2]) saw_ack2 = 1'b1;
        tick();
        total++; if (result_valid !== 4'b0001) begin bad++; $display("FAIL samp_valid got=%b want=0001", result_valid); end
        total++; if (result[23:0] !== 24'h000321) begin bad++; $display("FAIL samp_result got=%h want=000321", result[23:0]); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack[2]) saw_ack2 = 1'b1;
        end
        total++; if (saw_ack2) begin bad++; $display("FAIL samp_withdraw_ack2 got=1 want=0"); end
        total++; if (result[71:48] !== 24'h0) begin bad++; $display("FAIL samp_result2 got=%h want=000000", result[71:48]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL samp_idle got=%b want=0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0; req3 = '0;
        req_data = '0; req_data3 = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_reset_abort();
        test_latency3();
        test_sampling_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
